// File: rtl/dmem_responder_pkg.sv
// Shared types and encodings for the data-memory responder.
package dmem_responder_pkg;

  // Lifecycle: sweep memory to zero, take host preload, run core, freeze.
  typedef enum logic [1:0] {CLEAR, LOAD, RUN, DONE} mem_state_t;

  // RV32 load/store funct3 encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Store encodings only go up to a full word.
  function automatic logic f3_bad_store(input logic [2:0] f3);
    return (f3 > F3_W);
  endfunction

endpackage

// File: rtl/dmem_responder_mem_align.sv
// Sub-word lane steering: byte enables and replicated store data on the
// write side, lane select plus sign/zero extension on the read side, and
// alignment / encoding checks. Assumes 4 byte lanes (WIDTH = 32).
module mem_align
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_addr,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [WIDTH-1:0] i_rword,
  output logic [3:0]       o_byte_en,
  output logic [WIDTH-1:0] o_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_err
);

  logic [4:0]  w_bsh;
  logic [4:0]  w_hsh;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_bsh  = {i_addr, 3'b000};
  assign w_hsh  = {i_addr[1], 4'b0000};
  assign w_byte = i_rword[w_bsh +: 8];
  assign w_half = i_rword[w_hsh +: 16];

  // Decode access size: lanes, replicated write data, extended read data.
  always_comb begin
    o_byte_en = 4'b0000;
    o_wdata   = i_wdata;
    o_rdata   = '0;
    o_err     = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_byte_en = 4'b0001 << i_addr;
        o_wdata   = {4{i_wdata[7:0]}};
        o_rdata   = (i_funct3 == F3_B) ? {{(WIDTH-8){w_byte[7]}}, w_byte}
                                       : {{(WIDTH-8){1'b0}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_byte_en = i_addr[1] ? 4'b1100 : 4'b0011;
        o_wdata   = {2{i_wdata[15:0]}};
        o_rdata   = (i_funct3 == F3_H) ? {{(WIDTH-16){w_half[15]}}, w_half}
                                       : {{(WIDTH-16){1'b0}}, w_half};
        o_err     = i_addr[0];
      end
      F3_W: begin
        o_byte_en = 4'b1111;
        o_rdata   = i_rword;
        o_err     = (i_addr != 2'b00);
      end
      default: o_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory target for the core: word storage with sub-word access,
// plus the clear/preload/run/freeze lifecycle that gates the core.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DADDR = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [DADDR-1:0] dmem_addr,
  input  logic [WIDTH-1:0] dmem_wdata,
  input  logic             dmem_we,
  input  logic             dmem_re,
  input  logic [2:0]       dmem_funct3,
  output logic [WIDTH-1:0] dmem_rdata,
  input  logic             host_valid,
  output logic             host_ready,
  input  logic [DADDR-3:0] host_addr,
  input  logic [WIDTH-1:0] host_wdata,
  input  logic             host_done,
  output logic [WIDTH-1:0] host_rdata,
  input  logic             fin,
  output logic             core_run,
  output logic             done,
  output logic             acc_err
);

  localparam int AW    = DADDR - 2;
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] r_mem [DEPTH];
  mem_state_t       r_state;
  logic [AW-1:0]    r_cnt;
  logic             r_host_ready;
  logic             r_core_run;
  logic             r_done;
  logic             r_acc_err;

  logic [AW-1:0]    w_cidx;
  logic [WIDTH-1:0] w_rword;
  logic [3:0]       w_al_be;
  logic [WIDTH-1:0] w_al_wdata;
  logic [WIDTH-1:0] w_al_rdata;
  logic             w_al_err;
  logic             w_run;
  logic             w_err;
  logic             w_we;
  logic [AW-1:0]    w_widx;
  logic [WIDTH-1:0] w_wdata;
  logic [3:0]       w_be;

  assign w_cidx     = dmem_addr[DADDR-1:2];
  assign w_rword    = r_mem[w_cidx];
  assign host_rdata = r_mem[host_addr];
  assign w_run      = (r_state == RUN);

  mem_align #(.WIDTH(WIDTH)) u_align (
    .i_addr    (dmem_addr[1:0]),
    .i_funct3  (dmem_funct3),
    .i_wdata   (dmem_wdata),
    .i_rword   (w_rword),
    .o_byte_en (w_al_be),
    .o_wdata   (w_al_wdata),
    .o_rdata   (w_al_rdata),
    .o_err     (w_al_err)
  );

  // A store strobe with a load-only encoding is also illegal.
  assign w_err      = w_al_err | (dmem_we & f3_bad_store(dmem_funct3));
  assign dmem_rdata = (w_run && !w_err) ? w_al_rdata : '0;

  assign host_ready = r_host_ready;
  assign core_run   = r_core_run;
  assign done       = r_done;
  assign acc_err    = r_acc_err;

  // Pick the single write source for this cycle based on lifecycle state.
  always_comb begin
    w_we    = 1'b0;
    w_widx  = w_cidx;
    w_wdata = w_al_wdata;
    w_be    = w_al_be;
    case (r_state)
      CLEAR: begin
        w_we    = 1'b1;
        w_widx  = r_cnt;
        w_wdata = '0;
        w_be    = 4'b1111;
      end
      LOAD: begin
        w_we    = host_valid;
        w_widx  = host_addr;
        w_wdata = host_wdata;
        w_be    = 4'b1111;
      end
      RUN:     w_we = dmem_we & ~w_err;
      default: w_we = 1'b0;
    endcase
  end

  // Byte-enabled storage write; untouched lanes keep their contents.
  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_widx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  // Lifecycle FSM with registered status outputs and sticky error flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= CLEAR;
      r_cnt        <= '0;
      r_host_ready <= 1'b0;
      r_core_run   <= 1'b0;
      r_done       <= 1'b0;
      r_acc_err    <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '1) begin
            r_state      <= LOAD;
            r_host_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (host_done) begin
            r_state      <= RUN;
            r_host_ready <= 1'b0;
            r_core_run   <= 1'b1;
          end
        end
        RUN: begin
          if ((dmem_re || dmem_we) && w_err) r_acc_err <= 1'b1;
          if (fin) begin
            r_state    <= DONE;
            r_core_run <= 1'b0;
            r_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder for the pipelined datapath: the target of its dmem_addr / dmem_wdata / dmem_rdata initiator interface.
- Holds word storage and serves core loads and stores, including sub-word accesses with sign or zero extension.
- Runs a lifecycle FSM: clear memory, accept a host preload, gate the core run, and freeze after the core signals fin.
- Sits beside the datapath in the top level; core_run drives the core's reset_n gating.

Parameters:
- WIDTH, 32, data word width in bits.
- DADDR, 10, byte-address width; depth is 2^(DADDR-2) words.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- dmem_addr  in  DADDR  core byte address.
- dmem_wdata  in  WIDTH  core store data, right-aligned.
- dmem_we  in  1  core store strobe.
- dmem_re  in  1  core load strobe.
- dmem_funct3  in  3  access size/sign, RV32 load/store funct3 encoding.
- dmem_rdata  out  WIDTH  load data, extended, combinational.
- host_valid  in  1  host preload write request.
- host_ready  out  1  host write accepted this cycle.
- host_addr  in  DADDR-2  host word address (write and read).
- host_wdata  in  WIDTH  host preload word.
- host_done  in  1  host preload finished.
- host_rdata  out  WIDTH  word at host_addr, combinational, any state.
- fin  in  1  core ecall retire indication.
- core_run  out  1  core released from reset.
- done  out  1  core finished.
- acc_err  out  1  sticky misaligned or illegal access flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - State is CLEAR and the clear counter is 0.
  - host_ready=0, core_run=0, done=0, acc_err=0.
  - Storage is not reset directly; the CLEAR sweep zeroes it.
- CLEAR:
  - Writes 0 to word[cnt] each cycle, cnt+1.
  - When cnt reaches depth-1, that word is written and the state moves to LOAD.
  - Takes exactly 2^(DADDR-2) cycles.
- LOAD:
  - host_ready=1.
  - A write occurs when host_valid=1, with one cycle write latency.
  - host_done=1 moves to RUN next cycle; a simultaneous host_valid write is still performed.
- RUN:
  - core_run=1 and host_ready=0.
  - Core accesses are serviced; host writes are ignored.
- DONE:
  - Entered the cycle after fin=1 in RUN; a store in the fin cycle is still performed.
  - core_run=0, done=1; stays until reset.
- Outside RUN: core writes are suppressed, dmem_rdata=0, and no error is flagged.
- Reset mid-operation (any state): returns to CLEAR and memory is re-zeroed.
- Core reads:
  - Combinational; the word is selected by dmem_addr[DADDR-1:2], the lane by addr[1:0].
  - LB/LBU select byte addr[1:0]; LH/LHU select half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW returns the full word.
- Core writes:
  - Synchronous at the clk edge, using byte enables.
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to half addr[1].
  - SW writes the full word.
  - Untouched bytes are preserved.
- Same-cycle read and write to one word: read returns the old contents; the new data is visible next cycle.
- Errors (RUN only, when dmem_re or dmem_we is set):
  - Conditions: half access with addr[0]=1; word access with addr[1:0]!=0; funct3 in {011,110,111}; store funct3 >010.
  - Effect: write suppressed, dmem_rdata=0, acc_err set next cycle and sticky until reset.
- dmem_we=1 and dmem_re=1 together: the store is performed and rdata shows the old data.

Decomposition:
- lib_pkg additions:
  - mem_state_t enum {CLEAR, LOAD, RUN, DONE}.
  - funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010, F3_BU=3'b100, F3_HU=3'b101.
- Sub-module mem_align (combinational):
  - Inputs: addr[1:0], funct3, wdata, rword.
  - Outputs: byte_en[3:0], shifted wdata, extended rdata, err.
  - Keeps the FSM and storage in dmem_responder.

Test Plan:
- Reset, then idle -> host_ready rises exactly 256 cycles after reset_n deasserts (DADDR=10); host_rdata=0 at addresses 0 and 255.
- LOAD: write 0xDEADBEEF to word 3, then host_done -> core_run=1 next cycle; LW at 0x0C gives 0xDEADBEEF; LB at 0x0F gives 0xFFFFFFDE; LBU at 0x0F gives 0x000000DE; LH at 0x0C gives 0xFFFFBEEF.
- RUN: SB 0x55 at 0x0D on word 0xDEADBEEF -> next-cycle LW gives 0xDEAD55EF; SH 0x1234 at 0x0E gives 0x123455EF.
- RUN: LW at 0x02 -> dmem_rdata=0, acc_err=1 next cycle; then SW 0xAAAAAAAA at 0x05 -> memory unchanged, acc_err remains 1.
- RUN: SW 0x1 at 0x10 with fin=1 in the same cycle -> done=1, core_run=0 next cycle; host_rdata at word 4 = 0x1; later core stores ignored.
- Reset asserted during RUN after stores -> state CLEAR, core_run=0, acc_err=0; after the sweep, every location previously written reads 0.
